// File: rtl/id1000500b_convolution_coprocessor.sv
// id1000500b_convolution_coprocessor: memory-mapped 5-tap convolution engine.
// Define CONV_SIGNED_EN for two's-complement samples, kernel and results.
module id1000500b_convolution_coprocessor #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          Y_DEPTH     = 32,
    parameter int          Z_DEPTH     = Y_DEPTH + 4,
    parameter logic [39:0] KERNEL      = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [31:0] IP_ID_VALUE = 32'h1000500B
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  en_s,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  write,
    input  logic                  read,
    input  logic                  start,
    input  logic [4:0]            conf_dbus,
    output logic                  int_req
);
    localparam int YW = $clog2(Y_DEPTH);
    localparam int ZW = $clog2(Z_DEPTH);
    localparam int SW = $clog2(Y_DEPTH + 1);
    localparam int AW = 19;

    localparam logic [4:0] A_MMEM_Y  = 5'd0;
    localparam logic [4:0] A_AMEM_Y  = 5'd1;
    localparam logic [4:0] A_MMEM_Z  = 5'd2;
    localparam logic [4:0] A_AMEM_Z  = 5'd3;
    localparam logic [4:0] A_CSIZE_Y = 5'd4;
    localparam logic [4:0] A_STATUS  = 5'd30;
    localparam logic [4:0] A_IP_ID   = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_MAC, S_DONE} state_t;

    logic [7:0]    mem_y [Y_DEPTH];
    logic [AW-1:0] mem_z [Z_DEPTH];

    state_t        state;
    logic [YW-1:0] ptr_y;
    logic [ZW-1:0] ptr_z;
    logic [SW-1:0] size;
    logic [7:0]    mask;
    logic          busy;
    logic          done;
    logic [ZW-1:0] idx_i;
    logic [2:0]    idx_k;
    logic [AW-1:0] acc;

    logic [ZW-1:0]         last_i;
    logic [ZW-1:0]         tap_pos;
    logic                  tap_ok;
    logic [7:0]            x_k;
    logic [7:0]            y_k;
    logic [15:0]           prod;
    logic [AW-1:0]         prod_ext;
    logic [AW-1:0]         acc_next;
    logic [AW-1:0]         z_rd;
    logic [DATA_WIDTH-1:0] z_word;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  z_we;
    logic [AW-1:0]         z_wd;
    logic                  w1c_done;
    logic                  unused_bits;

    assign unused_bits = ^{data_in[DATA_WIDTH-1:24], data_in[15:8]};

    assign last_i   = ZW'(size) + ZW'(3);
    assign tap_pos  = idx_i - ZW'(idx_k);
    assign tap_ok   = (idx_i >= ZW'(idx_k)) && (tap_pos < ZW'(size));
    assign x_k      = KERNEL[{idx_k, 3'b000} +: 8];
    assign y_k      = mem_y[tap_pos[YW-1:0]];
    assign acc_next = acc + (tap_ok ? prod_ext : '0);
    assign z_rd     = mem_z[ptr_z];

`ifdef CONV_SIGNED_EN
    assign prod     = $signed(x_k) * $signed(y_k);
    assign prod_ext = {{(AW-16){prod[15]}}, prod};
    assign z_word   = {{(DATA_WIDTH-AW){z_rd[AW-1]}}, z_rd};
`else
    assign prod     = x_k * y_k;
    assign prod_ext = {{(AW-16){1'b0}}, prod};
    assign z_word   = {{(DATA_WIDTH-AW){1'b0}}, z_rd};
`endif

    assign w1c_done = write && (conf_dbus == A_STATUS) && data_in[0];
    assign int_req  = ~(done & mask[0]);

    // Z write port: zero fill during CLEAR, finished sum after the fifth tap
    always_comb begin
        z_we = 1'b0;
        z_wd = '0;
        if (en_s && !rst_a) begin
            if (state == S_CLEAR) begin
                z_we = 1'b1;
            end else if (state == S_MAC && idx_k == 3'd4) begin
                z_we = 1'b1;
                z_wd = acc_next;
            end
        end
    end

    // Host read data selection
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            conf_dbus == A_AMEM_Y:  rd_mux = DATA_WIDTH'(ptr_y);
            conf_dbus == A_MMEM_Z:  rd_mux = z_word;
            conf_dbus == A_AMEM_Z:  rd_mux = DATA_WIDTH'(ptr_z);
            conf_dbus == A_CSIZE_Y: rd_mux = DATA_WIDTH'(size);
            conf_dbus == A_STATUS:
                rd_mux = DATA_WIDTH'({8'd0, mask, 7'd0, busy, 7'd0, done});
            conf_dbus == A_IP_ID:   rd_mux = DATA_WIDTH'(IP_ID_VALUE);
            default:                rd_mux = '0;
        endcase
    end

    // Sample memory, written only by the host
    always_ff @(posedge clk) begin
        if (en_s && !rst_a && write && conf_dbus == A_MMEM_Y)
            mem_y[ptr_y] <= data_in[7:0];
    end

    // Result memory, written only by the engine
    always_ff @(posedge clk) begin
        if (z_we)
            mem_z[idx_i] <= z_wd;
    end

    // Host registers, pointers, status flags and the convolution FSM
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state    <= S_IDLE;
            ptr_y    <= '0;
            ptr_z    <= '0;
            size     <= '0;
            mask     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx_i    <= '0;
            idx_k    <= '0;
            acc      <= '0;
            data_out <= '0;
        end else if (en_s) begin
            if (write) begin
                case (conf_dbus)
                    A_MMEM_Y:
                        ptr_y <= (ptr_y == YW'(Y_DEPTH - 1)) ? '0 : ptr_y + YW'(1);
                    A_AMEM_Y:
                        ptr_y <= data_in[YW-1:0];
                    A_AMEM_Z:
                        ptr_z <= (data_in[ZW-1:0] >= ZW'(Z_DEPTH))
                               ? data_in[ZW-1:0] - ZW'(Z_DEPTH)
                               : data_in[ZW-1:0];
                    A_CSIZE_Y:
                        size <= (data_in[5:0] > 6'(Y_DEPTH))
                              ? SW'(Y_DEPTH) : SW'(data_in[5:0]);
                    A_STATUS:
                        mask <= data_in[23:16];
                    default: ;
                endcase
            end
            if (read) begin
                data_out <= rd_mux;
                if (conf_dbus == A_MMEM_Z)
                    ptr_z <= (ptr_z == ZW'(Z_DEPTH - 1)) ? '0 : ptr_z + ZW'(1);
            end
            if (w1c_done)
                done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        idx_i <= '0;
                        idx_k <= '0;
                        acc   <= '0;
                        state <= (size == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (idx_i == last_i) begin
                        idx_i <= '0;
                        state <= S_MAC;
                    end else begin
                        idx_i <= idx_i + ZW'(1);
                    end
                end
                S_MAC: begin
                    if (idx_k == 3'd4) begin
                        acc   <= '0;
                        idx_k <= '0;
                        if (idx_i == last_i)
                            state <= S_DONE;
                        else
                            idx_i <= idx_i + ZW'(1);
                    end else begin
                        acc   <= acc_next;
                        idx_k <= idx_k + 3'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_id1000500b_convolution_coprocessor.sv
// tb_id1000500b_convolution_coprocessor: scoreboard bench, directed and
// random convolution runs checked against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_id1000500b_convolution_coprocessor;
    localparam int YD = 32;
    localparam int ZD = 36;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        en_s = 1'b1;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  conf_dbus = '0;
    logic        int_req;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;
    logic [31:0] mon_e;
    string       mon_t;

    logic [7:0]  y_m [YD];
    logic [31:0] z_m [ZD];
    int py = 0;
    int pz = 0;
    int size_m = 0;
    int mask_m = 0;

    int exp10 [14] = '{1, 4, 10, 20, 35, 50, 65, 80, 95, 110, 114, 106, 85, 50};
    int exp1 [5] = '{3, 6, 9, 12, 15};

    always #5 clk = ~clk;

    id1000500b_convolution_coprocessor dut (
        .clk(clk),
        .rst_a(rst_a),
        .en_s(en_s),
        .data_in(data_in),
        .data_out(data_out),
        .write(write),
        .read(read),
        .start(start),
        .conf_dbus(conf_dbus),
        .int_req(int_req)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status(input int m, input bit b, input bit d);
        return {8'd0, 8'(m), 7'd0, b, 7'd0, d};
    endfunction

    function automatic int ysamp(input int j);
`ifdef CONV_SIGNED_EN
        return int'($signed(y_m[j]));
`else
        return int'(y_m[j]);
`endif
    endfunction

    // z[i] = sum over k of x[k]*y[i-k], x[k] = k+1, for i = 0..size+3
    function automatic void model_run();
        int acc;
        for (int i = 0; i < size_m + 4; i++) begin
            acc = 0;
            for (int k = 0; k < 5; k++)
                if (i - k >= 0 && i - k < size_m)
                    acc += (k + 1) * ysamp(i - k);
            z_m[i] = acc;
        end
    endfunction

    // monitor: a read sampled on a rising edge presents data_out after it
    always @(posedge clk) rd_seen <= read && en_s && !rst_a;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got %h expected none", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                check(mon_t, data_out, mon_e);
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        int v;
        conf_dbus = a;
        data_in = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        if (en_s) begin
            case (a)
                5'd0: begin
                    y_m[py] = d[7:0];
                    py = (py + 1) % YD;
                end
                5'd1: py = int'(d[4:0]);
                5'd3: begin
                    v = int'(d[5:0]);
                    pz = (v >= ZD) ? v - ZD : v;
                end
                5'd4: begin
                    v = int'(d[5:0]);
                    size_m = (v > YD) ? YD : v;
                end
                5'd30: mask_m = int'(d[23:16]);
                default: ;
            endcase
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string t);
        conf_dbus = a;
        read = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic rd_z(input int n, input string t);
        for (int j = 0; j < n; j++) begin
            rd(5'd2, z_m[pz], $sformatf("%s_z%0d", t, pz));
            pz = (pz + 1) % ZD;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string t);
        if (mask_m[0]) begin
            for (int c = 0; c < budget && int_req !== 1'b0; c++)
                @(negedge clk);
            check({t, "_irq"}, {31'd0, int_req}, 32'd0);
        end else begin
            repeat (budget) @(negedge clk);
            check({t, "_irq"}, {31'd0, int_req}, 32'd1);
        end
        rd(5'd30, status(mask_m, 1'b0, 1'b1), {t, "_status"});
    endtask

    task automatic run(input string t);
        int budget;
        budget = 2 * (size_m + 4) * 5 + 3;
        pulse_start();
        if (size_m > 0) model_run();
        wait_done(budget, t);
    endtask

    task automatic clear_done(input string t);
        wr(5'd30, {8'd0, 8'(mask_m), 15'd0, 1'b1});
        check({t, "_irq_clr"}, {31'd0, int_req}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;

        check("reset_irq", {31'd0, int_req}, 32'd1);
        rd(5'd31, 32'h1000500B, "ip_id");
        rd(5'd30, 32'h0, "reset_status");
        rd(5'd7, 32'h0, "unmapped");

        wr(5'd30, 32'h0001_0000);
        rd(5'd30, 32'h0001_0000, "mask_status");

        en_s = 1'b0;
        wr(5'd30, 32'h00FF_0001);
        en_s = 1'b1;
        rd(5'd30, 32'h0001_0000, "en_hold");

        wr(5'd1, 0);
        for (int j = 1; j <= 10; j++) wr(5'd0, j);
        wr(5'd4, 10);
        pulse_start();
        model_run();
        rd(5'd30, status(mask_m, 1'b1, 1'b0), "busy");
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_done(2 * 14 * 5 + 3, "run10");
        wr(5'd3, 0);
        pz = 0;
        for (int j = 0; j < 14; j++)
            rd(5'd2, exp10[j], $sformatf("run10_z%0d", j));
        wr(5'd3, 2);
        for (int j = 2; j < 5; j++)
            rd(5'd2, exp10[j], $sformatf("ptr2_z%0d", j));
        pz = 5;
        rd(5'd30, status(mask_m, 1'b0, 1'b1), "single_run");

        clear_done("run10");
        rd(5'd30, 32'h0001_0000, "w1c_status");

        wr(5'd30, 32'h0);
        wr(5'd1, 0);
        wr(5'd0, 3);
        wr(5'd4, 1);
        run("run1");
        wr(5'd3, 0);
        for (int j = 0; j < 5; j++)
            rd(5'd2, exp1[j], $sformatf("run1_z%0d", j));
        pz = 5;
        clear_done("run1");

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, YD);
            wr(5'd30, {8'd0, 8'($urandom_range(0, 255)), 16'd0});
            rd(5'd30, status(mask_m, 1'b0, 1'b0), $sformatf("rnd%0d_mask", r));
            wr(5'd1, 0);
            for (int j = 0; j < n; j++) wr(5'd0, $urandom);
            wr(5'd4, n);
            run($sformatf("rnd%0d", r));
            wr(5'd3, 0);
            rd_z(n + 4, $sformatf("rnd%0d", r));
            clear_done($sformatf("rnd%0d", r));
        end

        wr(5'd30, 32'h0001_0000);
        wr(5'd1, 0);
        for (int j = 0; j < 33; j++) wr(5'd0, $urandom);
        wr(5'd4, 32'h3F);
        rd(5'd4, 32'd32, "clamp_size");
        run("full");
        wr(5'd3, 0);
        rd_z(37, "full");
        clear_done("full");

        wr(5'd4, 32'h40);
        run("size0");
        wr(5'd3, 0);
        rd_z(4, "size0");
        clear_done("size0");

        wr(5'd4, 32);
        pulse_start();
        repeat (20) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        py = 0;
        pz = 0;
        size_m = 0;
        mask_m = 0;
        check("midrun_irq", {31'd0, int_req}, 32'd1);
        rd(5'd30, 32'h0, "midrun_status");
        run("post_reset_size0");
        clear_done("post_reset_size0");

        wr(5'd4, 4);
        run("recover");
        rd_z(8, "recover");

        repeat (3) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
